// File: rtl/i2c_apb_bridge_v2.sv
// i2c_apb_bridge_v2: APB-programmed I2C byte sequencer.
// Buffers bytes in TX/RX FIFOs and feeds an external byte engine.

module i2c_apb_bridge_v2_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 8,
  parameter int CW = $clog2(DEPTH) + 1
) (
  input  logic         PCLK,
  input  logic         PRESETn,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [CW-1:0] cnt,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          push_ok;
  logic          pop_ok;

  assign full    = cnt == CW'(DEPTH);
  assign empty   = cnt == '0;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rp];

  // pointer and level bookkeeping
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push_ok) wp <= wp + AW'(1);
      if (pop_ok)  rp <= rp + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // storage, no reset needed
  always_ff @(posedge PCLK) begin
    if (push_ok) mem[wp] <= din;
  end
endmodule

module i2c_apb_bridge_v2 #(
  parameter int FIFO_DEPTH = 8,
  parameter int PRESC_W = 16,
  parameter int PRESC_RST = 249
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [4:0]  PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        scl_tick,
  output logic        cmd_valid,
  output logic        cmd_start,
  output logic        cmd_stop,
  output logic        cmd_rw,
  output logic [7:0]  cmd_byte,
  input  logic        cmd_ready,
  input  logic        rsp_valid,
  input  logic        rsp_nack,
  input  logic [7:0]  rsp_byte,
  output logic        irq
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] DEPTH32 = FIFO_DEPTH;

  localparam logic [4:0] R_CTRL   = 5'h00;
  localparam logic [4:0] R_ADDR   = 5'h04;
  localparam logic [4:0] R_LEN    = 5'h08;
  localparam logic [4:0] R_PRESC  = 5'h0C;
  localparam logic [4:0] R_TX     = 5'h10;
  localparam logic [4:0] R_RX     = 5'h14;
  localparam logic [4:0] R_STATUS = 5'h18;

  typedef enum logic [2:0] {
    IDLE, ADDR, DATA, WAIT, STOP, DONE
  } state_t;

  state_t state, state_n;

  logic               en, rep, irq_en;
  logic [7:0]         addr_r;
  logic [LW-1:0]      len_r;
  logic [PRESC_W-1:0] presc_r;
  logic [PRESC_W-1:0] pcnt;
  logic               done_f, nack_f, ferr_f;

  logic [LW-1:0] rem, rem_n;
  logic          in_addr, in_addr_n;
  logic          stop_acc, stop_acc_n;

  logic          acc, wr, rd, busy;
  logic          cfg_err, go, abort;
  logic          wr_ctrl, wr_stat;
  logic          tx_push, tx_pop, tx_full, tx_empty;
  logic          rx_push, rx_pop, rx_full, rx_empty;
  logic          tx_ovf, rx_udf, rx_drop;
  logic          set_nack, set_done;
  logic [7:0]    tx_dout, rx_dout;
  logic [LW-1:0] tx_cnt, rx_cnt;
  logic          rd_xfer, last;
  logic [31:0]   status, rdata;

  assign acc     = PSEL && PENABLE;
  assign wr      = acc && PWRITE;
  assign rd      = acc && !PWRITE;
  assign busy    = state != IDLE;
  assign wr_ctrl = wr && PADDR == R_CTRL;
  assign wr_stat = wr && PADDR == R_STATUS;

  assign cfg_err = wr && ((busy && (PADDR == R_ADDR ||
                                    PADDR == R_LEN ||
                                    PADDR == R_PRESC)) ||
                          (PADDR == R_LEN && PWDATA > DEPTH32));

  assign go      = wr_ctrl && PWDATA[1] && PWDATA[0];
  assign abort   = wr_ctrl && !PWDATA[0];

  assign tx_push = wr && PADDR == R_TX && !tx_full;
  assign tx_ovf  = wr && PADDR == R_TX && tx_full;
  assign rx_pop  = rd && PADDR == R_RX && !rx_empty;
  assign rx_udf  = rd && PADDR == R_RX && rx_empty;

  assign rd_xfer = addr_r[0];
  assign last    = rem == LW'(1);

  assign PREADY  = 1'b1;
  assign PSLVERR = cfg_err;
  assign irq     = irq_en && (done_f || nack_f || ferr_f);
  assign scl_tick = en && (pcnt >= presc_r);

  i2c_apb_bridge_v2_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8),
    .CW    (LW)
  ) u_tx (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .push    (tx_push),
    .din     (PWDATA[7:0]),
    .pop     (tx_pop),
    .dout    (tx_dout),
    .cnt     (tx_cnt),
    .full    (tx_full),
    .empty   (tx_empty)
  );

  i2c_apb_bridge_v2_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8),
    .CW    (LW)
  ) u_rx (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .push    (rx_push),
    .din     (rsp_byte),
    .pop     (rx_pop),
    .dout    (rx_dout),
    .cnt     (rx_cnt),
    .full    (rx_full),
    .empty   (rx_empty)
  );

  // configuration registers; rejected writes leave them untouched
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      en      <= 1'b0;
      rep     <= 1'b0;
      irq_en  <= 1'b0;
      addr_r  <= '0;
      len_r   <= '0;
      presc_r <= PRESC_W'(PRESC_RST);
    end else begin
      if (wr_ctrl) begin
        en     <= PWDATA[0];
        rep    <= PWDATA[2];
        irq_en <= PWDATA[3];
      end
      if (!cfg_err && wr && PADDR == R_ADDR)  addr_r  <= PWDATA[7:0];
      if (!cfg_err && wr && PADDR == R_LEN)   len_r   <= PWDATA[LW-1:0];
      if (!cfg_err && wr && PADDR == R_PRESC) presc_r <= PWDATA[PRESC_W-1:0];
    end
  end

  // tick prescaler, held at zero while disabled
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)              pcnt <= '0;
    else if (!en)              pcnt <= '0;
    else if (pcnt >= presc_r)  pcnt <= '0;
    else                       pcnt <= pcnt + PRESC_W'(1);
  end

  // sticky status flags; a set event wins over a W1C clear
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      done_f <= 1'b0;
      nack_f <= 1'b0;
      ferr_f <= 1'b0;
    end else begin
      done_f <= (done_f && !(wr_stat && PWDATA[1])) || set_done;
      nack_f <= (nack_f && !(wr_stat && PWDATA[2])) || set_nack;
      ferr_f <= (ferr_f && !(wr_stat && PWDATA[3])) ||
                tx_ovf || rx_udf || rx_drop;
    end
  end

  // sequencer state and per-transfer counters
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state    <= IDLE;
      rem      <= '0;
      in_addr  <= 1'b0;
      stop_acc <= 1'b0;
    end else begin
      state    <= state_n;
      rem      <= rem_n;
      in_addr  <= in_addr_n;
      stop_acc <= stop_acc_n;
    end
  end

  // sequencer next state and command outputs
  always_comb begin
    state_n    = state;
    rem_n      = rem;
    in_addr_n  = in_addr;
    stop_acc_n = stop_acc;
    cmd_valid  = 1'b0;
    cmd_start  = 1'b0;
    cmd_stop   = 1'b0;
    cmd_rw     = 1'b0;
    cmd_byte   = 8'h00;
    tx_pop     = 1'b0;
    rx_push    = 1'b0;
    rx_drop    = 1'b0;
    set_nack   = 1'b0;
    set_done   = 1'b0;
    unique case (state)
      IDLE: begin
        if (go) begin
          state_n   = ADDR;
          rem_n     = len_r + LW'(1);
          in_addr_n = 1'b1;
        end
      end
      ADDR: begin
        cmd_valid = 1'b1;
        cmd_start = 1'b1;
        cmd_byte  = addr_r;
        cmd_stop  = last && !rep;
        if (cmd_ready) state_n = WAIT;
      end
      DATA: begin
        cmd_rw   = rd_xfer;
        cmd_stop = last && !rep;
        if (rd_xfer) begin
          cmd_valid = 1'b1;
        end else begin
          cmd_valid = !tx_empty;
          cmd_byte  = tx_dout;
        end
        if (cmd_valid && cmd_ready) begin
          state_n   = WAIT;
          in_addr_n = 1'b0;
          tx_pop    = !rd_xfer;
        end
      end
      WAIT: begin
        if (rsp_valid) begin
          if (rsp_nack && (in_addr || !rd_xfer)) begin
            set_nack = 1'b1;
            state_n  = STOP;
          end else begin
            if (!in_addr && rd_xfer) begin
              rx_push = !rx_full;
              rx_drop = rx_full;
            end
            rem_n   = rem - LW'(1);
            state_n = (rem_n == '0) ? DONE : DATA;
          end
        end
      end
      STOP: begin
        if (!stop_acc) begin
          cmd_valid = 1'b1;
          cmd_stop  = 1'b1;
          if (cmd_ready) stop_acc_n = 1'b1;
        end else if (rsp_valid) begin
          stop_acc_n = 1'b0;
          state_n    = DONE;
        end
      end
      DONE: begin
        set_done = !abort;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (abort) begin
      state_n    = IDLE;
      stop_acc_n = 1'b0;
    end
  end

  assign status = {8'h00, 8'(rx_cnt), 8'(tx_cnt),
                   rx_empty, rx_full, tx_empty, tx_full,
                   ferr_f, nack_f, done_f, busy};

  // register read mux; RXDATA shows the head being popped
  always_comb begin
    rdata = '0;
    case (PADDR)
      R_CTRL:   rdata = {28'h0, irq_en, rep, 1'b0, en};
      R_ADDR:   rdata = {24'h0, addr_r};
      R_LEN:    rdata = 32'(len_r);
      R_PRESC:  rdata = 32'(presc_r);
      R_RX:     rdata = rx_empty ? 32'h0 : {24'h0, rx_dout};
      R_STATUS: rdata = status;
      default:  rdata = '0;
    endcase
  end

  assign PRDATA = (rd && PRESETn) ? rdata : 32'h0;
endmodule

// File: tb/tb_i2c_apb_bridge_v2.sv
// tb_i2c_apb_bridge_v2: randomized bench with a byte-engine model
// and queue-based reference of expected commands and FIFO data.

module tb_i2c_apb_bridge_v2;
  localparam int DEPTH = 8;
  localparam logic [4:0] R_CTRL   = 5'h00;
  localparam logic [4:0] R_ADDR   = 5'h04;
  localparam logic [4:0] R_LEN    = 5'h08;
  localparam logic [4:0] R_PRESC  = 5'h0C;
  localparam logic [4:0] R_TX     = 5'h10;
  localparam logic [4:0] R_RX     = 5'h14;
  localparam logic [4:0] R_STATUS = 5'h18;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        PSEL, PENABLE, PWRITE;
  logic [4:0]  PADDR;
  logic [31:0] PWDATA, PRDATA;
  logic        PREADY, PSLVERR, scl_tick;
  logic        cmd_valid, cmd_start, cmd_stop, cmd_rw;
  logic [7:0]  cmd_byte;
  logic        cmd_ready, rsp_valid, rsp_nack;
  logic [7:0]  rsp_byte;
  logic        irq;

  typedef struct packed {
    logic       s;
    logic       p;
    logic       rw;
    logic [7:0] b;
  } cmd_t;

  int   n_chk = 0;
  int   n_fail = 0;
  cmd_t log_q[$];
  logic [7:0] eng_rx[$];
  logic [7:0] tx_m[$];
  logic [7:0] rx_m[$];
  bit   eng_on = 1'b1;
  bit   eng_nack = 1'b0;
  bit   irq_en_m = 1'b0;

  i2c_apb_bridge_v2 #(.FIFO_DEPTH(DEPTH)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .scl_tick(scl_tick),
    .cmd_valid(cmd_valid), .cmd_start(cmd_start),
    .cmd_stop(cmd_stop), .cmd_rw(cmd_rw), .cmd_byte(cmd_byte),
    .cmd_ready(cmd_ready), .rsp_valid(rsp_valid),
    .rsp_nack(rsp_nack), .rsp_byte(rsp_byte), .irq(irq)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic cmd_t mk(bit s, bit p, bit rw, logic [7:0] b);
    cmd_t c;
    c.s = s; c.p = p; c.rw = rw; c.b = b;
    return c;
  endfunction

  function automatic cmd_t cur_cmd();
    return mk(cmd_start, cmd_stop, cmd_rw, cmd_byte);
  endfunction

  // byte engine model: random accept and response latency
  task automatic serve();
    cmd_t c;
    int   d;
    int   r;
    bit   gone;
    c = cur_cmd();
    d = $urandom_range(0, 2);
    gone = 1'b0;
    for (int i = 0; i < d && !gone; i++) begin
      @(negedge PCLK);
      if (!cmd_valid) gone = 1'b1;
      else begin
        n_chk++;
        if (cur_cmd() !== c) begin
          n_fail++;
          $display("FAIL cmd_stable got %h exp %h", cur_cmd(), c);
        end
      end
    end
    if (!gone) begin
      cmd_ready = 1'b1;
      @(negedge PCLK);
      cmd_ready = 1'b0;
      log_q.push_back(c);
      r = $urandom_range(1, 3);
      for (int i = 0; i < r; i++) begin
        n_chk++;
        if (cmd_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL one_outstanding got %b exp 0", cmd_valid);
        end
        @(negedge PCLK);
      end
      rsp_valid = 1'b1;
      rsp_nack  = eng_nack && c.s;
      rsp_byte  = 8'h00;
      if (!c.s && c.rw && eng_rx.size() > 0)
        rsp_byte = eng_rx.pop_front();
      @(negedge PCLK);
      rsp_valid = 1'b0;
      rsp_nack  = 1'b0;
    end
  endtask

  initial begin
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_nack  = 1'b0;
    rsp_byte  = 8'h00;
    forever begin
      @(negedge PCLK);
      if (eng_on && PRESETn === 1'b1 && cmd_valid === 1'b1) serve();
    end
  end

  task automatic apb_wr(input logic [4:0] a, input logic [31:0] d,
                        output logic err);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
    PADDR = a; PWDATA = d;
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1 err = PSLVERR;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    logic e;
    apb_wr(a, d, e);
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1 d = PRDATA;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic push_tx(input logic [7:0] b);
    wr(R_TX, {24'h0, b});
    tx_m.push_back(b);
  endtask

  // one transfer checked against the expected command list
  task automatic run_xfer(input logic [6:0] sa, input bit rdx,
                          input int len, input bit rep, input bit seq);
    cmd_t        exp_q[$];
    logic [7:0]  b;
    logic [31:0] v;
    int          k;
    exp_q.push_back(mk(1'b1, (len == 0) && !rep, 1'b0, {sa, rdx}));
    for (int i = 0; i < len; i++) begin
      if (rdx) begin
        b = seq ? 8'(i) : 8'($urandom);
        eng_rx.push_back(b);
        rx_m.push_back(b);
        exp_q.push_back(mk(1'b0, (i == len - 1) && !rep, 1'b1, 8'h00));
      end else begin
        exp_q.push_back(mk(1'b0, (i == len - 1) && !rep, 1'b0,
                           tx_m.pop_front()));
      end
    end
    log_q.delete();
    wr(R_ADDR, {24'h0, sa, rdx});
    wr(R_LEN, 32'(len));
    wr(R_CTRL, {28'h0, irq_en_m, rep, 2'b11});
    k = 0;
    do begin
      rd(R_STATUS, v);
      k++;
    end while (!v[1] && k < 200);
    n_chk++;
    if (v[1:0] !== 2'b10) begin
      n_fail++;
      $display("FAIL xfer_done status %h exp done=1 busy=0", v);
    end
    n_chk++;
    if (log_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL cmd_count got %0d exp %0d",
               log_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      n_chk++;
      if (log_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL cmd[%0d] got %h exp %h", i, log_q[i], exp_q[i]);
      end
    end
    n_chk++;
    if (v[23:8] !== {8'(rx_m.size()), 8'(tx_m.size())}) begin
      n_fail++;
      $display("FAIL levels got %h exp rx=%0d tx=%0d",
               v[23:8], rx_m.size(), tx_m.size());
    end
    wr(R_STATUS, 32'h2);
  endtask

  task automatic drain_rx();
    logic [31:0] v;
    while (rx_m.size() > 0) begin
      rd(R_RX, v);
      n_chk++;
      if (v !== {24'h0, rx_m[0]}) begin
        n_fail++;
        $display("FAIL rx_pop got %h exp %h", v, rx_m[0]);
      end
      void'(rx_m.pop_front());
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    PRESETn = 1'b0;
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0;
    PADDR = R_STATUS; PWDATA = '0;
    repeat (3) @(negedge PCLK);
    #1;
    n_chk++;
    if ({cmd_valid, scl_tick, irq, PSLVERR, PRDATA} !== 36'h0) begin
      n_fail++;
      $display("FAIL rst_outputs got v%b t%b i%b e%b d%h exp all 0",
               cmd_valid, scl_tick, irq, PSLVERR, PRDATA);
    end
    PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge PCLK);
    PRESETn = 1'b1;
    rd(R_STATUS, v);
    n_chk++;
    if (v !== 32'hA0) begin
      n_fail++;
      $display("FAIL rst_status got %h exp 000000a0", v);
    end
    rd(R_PRESC, v);
    n_chk++;
    if (v !== 32'd249) begin
      n_fail++;
      $display("FAIL rst_presc got %0d exp 249", v);
    end
    rd(R_CTRL, v);
    n_chk++;
    if (v !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_ctrl got %h exp 0", v);
    end
  endtask

  task automatic test_prescaler();
    int p;
    int cnt;
    int lastt;
    for (int r = 0; r < 3; r++) begin
      p = (r == 0) ? 3 : (r == 1) ? $urandom_range(1, 6) : 0;
      wr(R_CTRL, 32'h0);
      wr(R_PRESC, 32'(p));
      wr(R_CTRL, 32'h1);
      cnt = 0;
      lastt = -1;
      for (int i = 0; i < 4 * (p + 1); i++) begin
        @(negedge PCLK);
        if (scl_tick) begin
          if (lastt >= 0) begin
            n_chk++;
            if (i - lastt !== p + 1) begin
              n_fail++;
              $display("FAIL tick_gap got %0d exp %0d", i - lastt, p + 1);
            end
          end
          lastt = i;
          cnt++;
        end
      end
      n_chk++;
      if (cnt !== 4) begin
        n_fail++;
        $display("FAIL tick_count presc=%0d got %0d exp 4", p, cnt);
      end
    end
    wr(R_CTRL, 32'h0);
    cnt = 0;
    repeat (8) begin
      @(negedge PCLK);
      if (scl_tick) cnt++;
    end
    n_chk++;
    if (cnt !== 0) begin
      n_fail++;
      $display("FAIL tick_disabled got %0d exp 0", cnt);
    end
  endtask

  task automatic test_write_xfer();
    logic [31:0] v;
    push_tx(8'h55);
    push_tx(8'hAA);
    run_xfer(7'h50, 1'b0, 2, 1'b0, 1'b0);
    rd(R_STATUS, v);
    n_chk++;
    if (v[5] !== 1'b1) begin
      n_fail++;
      $display("FAIL tx_empty_after got %b exp 1", v[5]);
    end
    for (int r = 0; r < 3; r++) begin
      int n;
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) push_tx(8'($urandom));
      run_xfer(7'($urandom), 1'b0, n, 1'($urandom), 1'b0);
    end
  endtask

  task automatic test_read_xfer();
    logic [31:0] v;
    run_xfer(7'h50, 1'b1, DEPTH, 1'b0, 1'b1);
    rd(R_STATUS, v);
    n_chk++;
    if ({v[6], v[3]} !== 2'b10) begin
      n_fail++;
      $display("FAIL rx_full_noferr got full=%b ferr=%b exp 1 0",
               v[6], v[3]);
    end
    drain_rx();
    rd(R_RX, v);
    n_chk++;
    if (v !== 32'h0) begin
      n_fail++;
      $display("FAIL rx_underflow_data got %h exp 0", v);
    end
    rd(R_STATUS, v);
    n_chk++;
    if (v[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL rx_underflow_ferr got %b exp 1", v[3]);
    end
    wr(R_STATUS, 32'h8);
    for (int r = 0; r < 2; r++) begin
      run_xfer(7'($urandom), 1'b1, $urandom_range(1, 4),
               1'($urandom), 1'b0);
      drain_rx();
    end
  endtask

  task automatic test_nack();
    logic [31:0] v;
    int k;
    irq_en_m = 1'b1;
    eng_nack = 1'b1;
    log_q.delete();
    wr(R_ADDR, 32'hA1);
    wr(R_LEN, 32'd1);
    wr(R_CTRL, 32'hB);
    k = 0;
    do begin
      rd(R_STATUS, v);
      k++;
    end while (!v[1] && k < 200);
    n_chk++;
    if (v[2:0] !== 3'b110) begin
      n_fail++;
      $display("FAIL nack_status got %b exp 110", v[2:0]);
    end
    n_chk++;
    if (log_q.size() !== 2 ||
        log_q[log_q.size() - 1] !== mk(1'b0, 1'b1, 1'b0, 8'h00)) begin
      n_fail++;
      $display("FAIL nack_stop_cmd got n=%0d exp 2 cmds ending in stop",
               log_q.size());
    end
    n_chk++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_set got %b exp 1", irq);
    end
    eng_nack = 1'b0;
    wr(R_STATUS, 32'h6);
    #1;
    n_chk++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_clear got %b exp 0", irq);
    end
    irq_en_m = 1'b0;
    wr(R_CTRL, 32'h1);
  endtask

  task automatic test_busy_abort();
    logic [31:0] v;
    logic        e;
    int          k;
    eng_on = 1'b0;
    push_tx(8'($urandom));
    wr(R_ADDR, 32'hB0);
    wr(R_LEN, 32'd1);
    wr(R_CTRL, 32'h3);
    k = 0;
    while (cmd_valid !== 1'b1 && k < 20) begin
      @(negedge PCLK);
      k++;
    end
    n_chk++;
    if (cmd_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_start got %b exp 1", cmd_valid);
    end
    apb_wr(R_LEN, 32'd0, e);
    n_chk++;
    if (e !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_len_err got %b exp 1", e);
    end
    rd(R_LEN, v);
    n_chk++;
    if (v !== 32'd1) begin
      n_fail++;
      $display("FAIL busy_len_kept got %0d exp 1", v);
    end
    wr(R_CTRL, 32'h0);
    #1;
    n_chk++;
    if (cmd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_valid got %b exp 0", cmd_valid);
    end
    rd(R_STATUS, v);
    n_chk++;
    if ({v[15:8], v[1:0]} !== {8'(tx_m.size()), 2'b00}) begin
      n_fail++;
      $display("FAIL abort_status got %h exp tx=%0d busy=0 done=0",
               v, tx_m.size());
    end
    eng_on = 1'b1;
    apb_wr(R_LEN, 32'(DEPTH + 1), e);
    n_chk++;
    if (e !== 1'b1) begin
      n_fail++;
      $display("FAIL len_range_err got %b exp 1", e);
    end
    apb_wr(R_LEN, 32'(DEPTH), e);
    rd(R_LEN, v);
    n_chk++;
    if ({e, v} !== {1'b0, 32'(DEPTH)}) begin
      n_fail++;
      $display("FAIL len_legal got err=%b len=%0d exp 0 %0d",
               e, v, DEPTH);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    while (tx_m.size() < DEPTH) push_tx(8'($urandom));
    wr(R_TX, 32'h0000_00EE);
    rd(R_STATUS, v);
    n_chk++;
    if ({v[15:8], v[4], v[3]} !== {8'(DEPTH), 2'b11}) begin
      n_fail++;
      $display("FAIL tx_overflow got %h exp level=%0d full=1 ferr=1",
               v, DEPTH);
    end
    wr(R_STATUS, 32'h8);
    run_xfer(7'($urandom), 1'b0, DEPTH, 1'($urandom), 1'b0);
    run_xfer(7'($urandom), 1'b1, $urandom_range(1, DEPTH),
             1'($urandom), 1'b0);
    drain_rx();
    push_tx(8'($urandom));
    run_xfer(7'($urandom), 1'b0, 1, 1'b0, 1'b0);
  endtask

  initial begin
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0;
    test_reset();
    test_prescaler();
    test_write_xfer();
    test_read_xfer();
    test_nack();
    test_busy_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/i2c_apb_bridge_v2.md
I2C_APB_BRIDGE_V2 -- requirements
Module: i2c_apb_bridge_v2

Interface
REQ-001 Parameter FIFO_DEPTH, 8, TX and RX FIFO depth in bytes; power of 2, range 2..64.
REQ-002 Parameter PRESC_W, 16, width of the prescaler register and counter.
REQ-003 Parameter PRESC_RST, 249, reset value of PRESC (100 kHz tick base).
REQ-004 PCLK  in  1  sole clock; all logic on the rising edge.
REQ-005 PRESETn  in  1  asynchronous, active-low reset.
REQ-006 PSEL, PENABLE, PWRITE  in  1 each  APB control.
REQ-007 PADDR  in  5  byte address.
REQ-008 PWDATA  in  32  write data.
REQ-009 PRDATA  out  32  read data.
REQ-010 PREADY  out  1  tied to 1; zero wait states.
REQ-011 PSLVERR  out  1  error response, valid in the access phase.
REQ-012 scl_tick  out  1  one-cycle pulse feeding the byte engine.
REQ-013 cmd_valid, cmd_start, cmd_stop, cmd_rw  out  1 each  byte-command request and flags.
REQ-014 cmd_byte  out  8  byte to transmit.
REQ-015 cmd_ready  in  1  engine accepts the command.
REQ-016 rsp_valid, rsp_nack  in  1 each  byte done; slave NACKed.
REQ-017 rsp_byte  in  8  received byte.
REQ-018 irq  out  1  level interrupt.

Function
REQ-019 Register map:
- 0x00 CTRL: [0] EN, [1] GO (self-clearing), [2] REP (end with repeated start, no stop), [3] IRQ_EN.
- 0x04 ADDR: [7:1] slave address, [0] RW (1 = read).
- 0x08 LEN: byte count, 0..FIFO_DEPTH.
- 0x0C PRESC.
- 0x10 TXDATA: write-only; a write pushes [7:0].
- 0x14 RXDATA: read-only; a read pops.
- 0x18 STATUS.
REQ-020 STATUS layout: [0] BUSY, [1] DONE (W1C), [2] NACK (W1C), [3] FERR (W1C), [4] TX_FULL, [5] TX_EMPTY, [6] RX_FULL, [7] RX_EMPTY, [15:8] TX level, [23:16] RX level.
REQ-021 Writes and pops take effect only when PSEL, PENABLE and the access phase are all true; unmapped reads return 0.
REQ-022 A write to ADDR, LEN or PRESC while BUSY, or a LEN write > FIFO_DEPTH, is discarded with PSLVERR=1.
REQ-023 Prescaler counts 0..PRESC while EN=1; scl_tick=1 in the cycle the count equals PRESC, then the counter wraps to 0. PRESC=0 gives a tick every cycle. EN=0 holds the counter at 0 with no ticks.
REQ-024 TXDATA write when TX is full, or RXDATA read when RX is empty, sets FERR and leaves the FIFO unchanged; such a read returns 0.
REQ-025 Sequencer states are IDLE, ADDR, DATA, WAIT, STOP, DONE.
REQ-026 IDLE: GO with EN=1 moves to ADDR and sets BUSY. GO with EN=0 is ignored.
REQ-027 ADDR: drive cmd_valid=1, cmd_start=1, cmd_byte={addr,RW}, cmd_rw=0; cmd_stop=!REP only if LEN=0. Move to WAIT on cmd_ready.
REQ-028 cmd_valid and all cmd_* signals stay stable from assertion until cmd_ready. At most one command is outstanding; the next is issued only after rsp_valid.
REQ-029 DATA, write transfer: requires TX non-empty; otherwise cmd_valid=0 and the sequencer stalls. The TX pop occurs on cmd_ready.
REQ-030 DATA, read transfer: cmd_rw=1 and cmd_byte=0. rsp_byte is pushed to RX on rsp_valid; if RX is full, FERR is set and the byte is dropped.
REQ-031 The last data command carries cmd_stop=!REP; cmd_start=0 on every data command.
REQ-032 WAIT: rsp_valid with rsp_nack=1 on the address or a write byte sets NACK and moves to STOP. Otherwise decrement the remaining count, then go to DATA if count > 0, else to DONE.
REQ-033 STOP: issue cmd_stop=1, cmd_byte=0 and wait for its rsp_valid, then go to DONE.
REQ-034 DONE: set DONE, clear BUSY, return to IDLE; total one cycle.
REQ-035 irq = IRQ_EN & (DONE | NACK | FERR).
REQ-036 EN cleared while BUSY: next cycle the sequencer is in IDLE, cmd_valid=0, BUSY=0, DONE is not set, and FIFO contents are retained.
REQ-037 A W1C write coinciding with a set event leaves the bit set.

Reset
REQ-038 While PRESETn=0 the following hold:
- all registers 0 except PRESC=PRESC_RST;
- FIFOs empty, so STATUS=0x0000_00A0;
- sequencer in IDLE;
- cmd_valid=0, scl_tick=0, irq=0, PSLVERR=0, PRDATA=0.
REQ-039 Reset release needs no APB activity before first use.

Verification
REQ-040 Reset, then read STATUS -> 0x000000A0; read PRESC -> 249.
REQ-041 EN=1, PRESC=3 -> scl_tick every 4th PCLK; PRESC=0 -> tick every cycle.
REQ-042 Write 0x55, 0xAA to TX; ADDR=0xA0, LEN=2, GO; engine acks all -> three commands:
- 0xA0 with start=1;
- 0x55;
- 0xAA with stop=1.
Then DONE=1, TX empty.
REQ-043 Read transfer: ADDR=0xA1, LEN=FIFO_DEPTH, engine returns 0..7 -> RX_FULL=1, no FERR; eight pops return 0..7; a ninth pop returns 0 with FERR=1.
REQ-044 Engine NACKs the address byte -> next command has stop=1; NACK=1, DONE=1, irq=1 with IRQ_EN=1; write 0x6 to STATUS -> irq=0.
REQ-045 Write LEN while BUSY -> PSLVERR=1 and LEN unchanged; clear EN mid-transfer -> IDLE next cycle with cmd_valid=0.
